// File: rtl/m_uart_master.sv
// ---------------------------------------------------------------------------
// m_uart_master -- UART transmitter with a one-entry holding register.
//
// Serializes a WORD-bit parallel word onto TXD as: start bit (0), WORD data
// bits (MSB or LSB first), optional even/odd parity bit, STOP_BITS stop bits
// (1). Each line bit lasts CLK_FREQ/BAUD_RATE clocks. A word may be queued
// in the holding register while a frame is in flight. When it is, the next
// frame starts right after the last stop bit, with no idle bit in between.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   data_i  in   [WORD-1:0] word to send, sampled when send && ready
//   send    in   request strobe
//   TXD     out  serial line, idles high
//   ready   out  holding register empty (a send is accepted this cycle)
//   busy    out  frame in progress (state != IDLE)
//   state   out  [2:0] IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
//   done    out  one-cycle pulse during the final clock of each frame
//   error   out  sticky overflow / illegal-state flag
// ---------------------------------------------------------------------------
module m_uart_master #(
    parameter int WORD      = 8,
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 16_000_000,
    parameter int DIV_BOC   = 12,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] data_i,
    input  logic            send,
    output logic            TXD,
    output logic            ready,
    output logic            busy,
    output logic [2:0]      state,
    output logic            done,
    output logic            error
);

    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int BIT_W   = $clog2(WORD + 2);

    localparam logic [DIV_BOC-1:0] DIV_LAST  = DIV_BOC'(DIVISOR - 1);
    localparam logic [BIT_W-1:0]   WORD_LAST = BIT_W'(WORD - 1);
    localparam logic [BIT_W-1:0]   STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a frame: XOR of data (even) or its inverse (odd).
    function automatic logic f_parity(input logic [WORD-1:0] d);
        if (PARITY == 2) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    // Next data bit to put on the line, in the configured bit order.
    function automatic logic f_out_bit(input logic [WORD-1:0] sh);
        if (MSB_FIRST != 0) begin
            return sh[WORD-1];
        end else begin
            return sh[0];
        end
    endfunction

    // Shift register after one data bit has been consumed.
    function automatic logic [WORD-1:0] f_advance(input logic [WORD-1:0] sh);
        if (MSB_FIRST != 0) begin
            return {sh[WORD-2:0], 1'b0};
        end else begin
            return {1'b0, sh[WORD-1:1]};
        end
    endfunction

    state_t              state_r, state_s;
    logic [DIV_BOC-1:0]  div_r, div_s;
    logic [BIT_W-1:0]    bit_r, bit_s;
    logic [WORD-1:0]     shift_r, shift_s;
    logic                parity_r, parity_s;
    logic [WORD-1:0]     hold_r, hold_s;
    logic                hold_valid_r, hold_valid_s;
    logic                txd_r, txd_s;
    logic                ready_r, ready_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                error_r, error_s;
    logic                load_s;
    logic                bit_end_s;

    // Next-state, datapath and output computation for the transmit FSM.
    always_comb begin
        state_s      = state_r;
        div_s        = div_r;
        bit_s        = bit_r;
        shift_s      = shift_r;
        parity_s     = parity_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        txd_s        = txd_r;
        error_s      = error_r;
        load_s       = 1'b0;
        bit_end_s    = (div_r == DIV_LAST);

        case (state_r)
            ST_IDLE: begin
                txd_s = 1'b1;
                if (hold_valid_r) begin
                    load_s = 1'b1;
                end else begin
                    div_s = '0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    div_s   = '0;
                    bit_s   = '0;
                    txd_s   = f_out_bit(shift_r);
                    shift_s = f_advance(shift_r);
                end else begin
                    div_s = div_r + DIV_BOC'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    div_s = '0;
                    if (bit_r == WORD_LAST) begin
                        bit_s = '0;
                        if (PARITY != 0) begin
                            state_s = ST_PARITY;
                            txd_s   = parity_r;
                        end else begin
                            state_s = ST_STOP;
                            txd_s   = 1'b1;
                        end
                    end else begin
                        bit_s   = bit_r + BIT_W'(1);
                        txd_s   = f_out_bit(shift_r);
                        shift_s = f_advance(shift_r);
                    end
                end else begin
                    div_s = div_r + DIV_BOC'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    div_s   = '0;
                    bit_s   = '0;
                    txd_s   = 1'b1;
                end else begin
                    div_s = div_r + DIV_BOC'(1);
                end
            end
            ST_STOP: begin
                txd_s = 1'b1;
                if (bit_end_s) begin
                    div_s = '0;
                    // bit_r counts stop bits here
                    if (bit_r == STOP_LAST) begin
                        if (hold_valid_r) begin
                            load_s = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                            bit_s   = '0;
                        end
                    end else begin
                        bit_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    div_s = div_r + DIV_BOC'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                div_s   = '0;
                bit_s   = '0;
                txd_s   = 1'b1;
                error_s = 1'b1;
            end
        endcase

        // Move the holding register into the shifter and begin a start bit.
        if (load_s) begin
            state_s      = ST_START;
            div_s        = '0;
            bit_s        = '0;
            shift_s      = hold_r;
            parity_s     = f_parity(hold_r);
            txd_s        = 1'b0;
            hold_valid_s = 1'b0;
        end else begin
            parity_s = parity_r;
        end

        // Acceptance uses the registered ready. A send while ready is low
        // is an overflow even if the holding register drains on this edge.
        if (send) begin
            if (ready_r) begin
                hold_s       = data_i;
                hold_valid_s = 1'b1;
            end else begin
                error_s = 1'b1;
            end
        end else begin
            hold_s = hold_r;
        end

        ready_s = ~hold_valid_s;
        busy_s  = (state_s != ST_IDLE);
        // Flag the cycle that will be the last clock of the final stop bit.
        done_s  = (state_s == ST_STOP) && (div_s == DIV_LAST) &&
                  (bit_s == STOP_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            div_r        <= '0;
            bit_r        <= '0;
            shift_r      <= '0;
            parity_r     <= 1'b0;
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            txd_r        <= 1'b1;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            div_r        <= div_s;
            bit_r        <= bit_s;
            shift_r      <= shift_s;
            parity_r     <= parity_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            txd_r        <= txd_s;
            ready_r      <= ready_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
        end
    end

    assign TXD   = txd_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign state = state_r;
    assign done  = done_r;
    assign error = error_r;

endmodule

// File: tb/tb_m_uart_master.sv
// ---------------------------------------------------------------------------
// tb_m_uart_master -- directed plus randomized bench for m_uart_master.
// Four instances (DIVISOR = 8): default, even parity, odd parity, and
// 2 stop bits with LSB first. Expected line waveforms come from a frame
// model that builds a list of line bits from the data and the parameters.
// ---------------------------------------------------------------------------
module tb_m_uart_master;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset_s;
    logic       send_s;
    logic [1:0] sel_s;
    logic [7:0] data_s;
    logic [3:0] send_v;
    logic [3:0] txd_v, ready_v, busy_v, done_v, error_v;
    logic [2:0] state_v [4];

    int checks = 0;
    int errors = 0;
    logic [7:0] stim_q[$];

    always #5 clk = ~clk;

    assign send_v = send_s ? (4'b0001 << sel_s) : 4'b0000;

    m_uart_master #(.CLK_FREQ(8), .BAUD_RATE(1)) u_dut0 (
        .clk(clk), .reset(reset_s), .data_i(data_s), .send(send_v[0]),
        .TXD(txd_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .state(state_v[0]), .done(done_v[0]), .error(error_v[0]));

    m_uart_master #(.CLK_FREQ(8), .BAUD_RATE(1), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset_s), .data_i(data_s), .send(send_v[1]),
        .TXD(txd_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .state(state_v[1]), .done(done_v[1]), .error(error_v[1]));

    m_uart_master #(.CLK_FREQ(8), .BAUD_RATE(1), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset_s), .data_i(data_s), .send(send_v[2]),
        .TXD(txd_v[2]), .ready(ready_v[2]), .busy(busy_v[2]),
        .state(state_v[2]), .done(done_v[2]), .error(error_v[2]));

    m_uart_master #(.CLK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(2), .MSB_FIRST(0)) u_dut3 (
        .clk(clk), .reset(reset_s), .data_i(data_s), .send(send_v[3]),
        .TXD(txd_v[3]), .ready(ready_v[3]), .busy(busy_v[3]),
        .state(state_v[3]), .done(done_v[3]), .error(error_v[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge. Queued
    // sends are replayed one per cycle; otherwise data_i is scrambled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (stim_q.size() > 0) begin
            data_s = stim_q.pop_front();
            send_s = 1'b1;
        end else begin
            send_s = 1'b0;
            data_s = 8'($urandom);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check({tag, "_txd"},   32'(txd_v[u]),   32'd1);
        check({tag, "_ready"}, 32'(ready_v[u]), 32'd1);
        check({tag, "_busy"},  32'(busy_v[u]),  32'd0);
        check({tag, "_state"}, 32'(state_v[u]), 32'd0);
        check({tag, "_done"},  32'(done_v[u]),  32'd0);
    endtask

    // Send d on instance u. Returns positioned at the first cycle of the
    // start bit (one edge after acceptance).
    task automatic send_and_start(input int u, input logic [7:0] d);
        sel_s  = 2'(u);
        data_s = d;
        send_s = 1'b1;
        tick();
        check("accept_ready", 32'(ready_v[u]), 32'd0);
        check("accept_txd",   32'(txd_v[u]),   32'd1);
        tick();
        check("start_txd",   32'(txd_v[u]),   32'd0);
        check("start_state", 32'(state_v[u]), 32'd1);
        check("start_busy",  32'(busy_v[u]),  32'd1);
        check("start_ready", 32'(ready_v[u]), 32'd1);
    endtask

    // Reference frame: list of line bits, each DIV clocks long. Checks TXD
    // and done on every clock; returns positioned on the frame's last clock.
    task automatic expect_frame(input int u, input logic [7:0] d, input int par,
                                input int stops, input bit msb);
        logic fb[$];
        int   len;
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            fb.push_back(msb ? d[7-i] : d[i]);
        end
        if (par != 0) begin
            fb.push_back((^d) ^ (par == 2));
        end
        for (int i = 0; i < stops; i++) begin
            fb.push_back(1'b1);
        end
        len = fb.size() * DIV;
        for (int c = 0; c < len; c++) begin
            check("frame_txd",  32'(txd_v[u]),  32'(fb[c / DIV]));
            check("frame_done", 32'(done_v[u]), 32'(c == len - 1));
            if (c != len - 1) begin
                tick();
            end
        end
    endtask

    initial begin
        logic [7:0] b1, b2, b3;
        reset_s = 1'b1;
        send_s  = 1'b0;
        sel_s   = 2'd0;
        data_s  = 8'h00;

        // 1: reset state, then a single 8'hA5 frame
        tick();
        tick();
        check_idle(0, "reset");
        check("reset_error", 32'(error_v[0]), 32'd0);
        reset_s = 1'b0;
        send_and_start(0, 8'hA5);
        expect_frame(0, 8'hA5, 0, 1, 1'b1);
        tick();
        check_idle(0, "t1_after");

        // 2: 8'h00 then 8'hFF queued during START, back-to-back frames
        send_and_start(0, 8'h00);
        data_s = 8'hFF;
        send_s = 1'b1;
        expect_frame(0, 8'h00, 0, 1, 1'b1);
        tick();
        check("b2b_state", 32'(state_v[0]), 32'd1);
        expect_frame(0, 8'hFF, 0, 1, 1'b1);
        tick();
        check_idle(0, "t2_after");
        check("t2_error", 32'(error_v[0]), 32'd0);

        // 3: third byte on a ready-low cycle is dropped and flags error
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        send_and_start(0, b1);
        data_s = b2;
        send_s = 1'b1;
        stim_q.push_back(b3);
        expect_frame(0, b1, 0, 1, 1'b1);
        tick();
        expect_frame(0, b2, 0, 1, 1'b1);
        tick();
        check_idle(0, "t3_after");
        check("t3_error", 32'(error_v[0]), 32'd1);

        // 4: even and odd parity on 8'h07
        send_and_start(1, 8'h07);
        expect_frame(1, 8'h07, 1, 1, 1'b1);
        tick();
        check_idle(1, "t4_even");
        send_and_start(2, 8'h07);
        expect_frame(2, 8'h07, 2, 1, 1'b1);
        tick();
        check_idle(2, "t4_odd");

        // 5: reset during data bit 3 of 8'h55
        send_and_start(0, 8'h55);
        for (int i = 0; i < 35; i++) begin
            tick();
        end
        reset_s = 1'b1;
        tick();
        reset_s = 1'b0;
        check_idle(0, "t5_reset");
        check("t5_error", 32'(error_v[0]), 32'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t5_quiet_done", 32'(done_v[0]), 32'd0);
            check("t5_quiet_txd",  32'(txd_v[0]),  32'd1);
        end
        send_and_start(0, 8'h3C);
        expect_frame(0, 8'h3C, 0, 1, 1'b1);
        tick();
        check_idle(0, "t5_after");

        // 6: two stop bits, LSB first
        send_and_start(3, 8'h01);
        expect_frame(3, 8'h01, 0, 2, 1'b0);
        tick();
        check_idle(3, "t6_after");

        // randomized frames on the default and LSB-first instances
        for (int k = 0; k < 6; k++) begin
            int u;
            u  = (k % 2 == 1) ? 3 : 0;
            b1 = 8'($urandom);
            send_and_start(u, b1);
            expect_frame(u, b1, 0, (u == 3) ? 2 : 1, (u == 0));
            tick();
            check_idle(u, "rand_after");
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
            end
        end
        check("final_error3", 32'(error_v[3]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
